// File: rtl/vs0_decoupler_pkg.sv
// ----------------------------------------------------------------------------
// vs_decoupler_pkg
// Shared types and default constants for the VS0 DFX decoupler.
//   dec_state_t            : isolation sequencer states
//   DRAIN_TIMEOUT_DEFAULT  : cycles allowed for in-flight traffic to drain
//   RST_CYCLES_DEFAULT     : cycles VS0 reset is held low while recoupling
//   OUTST_W_DEFAULT        : width of the outstanding-transaction counters
//   timer_width()          : bits needed by a timer reaching max(a,b)-1
// ----------------------------------------------------------------------------
package vs_decoupler_pkg;

    typedef enum logic [1:0] {
        ST_COUPLED   = 2'd0,
        ST_DRAIN     = 2'd1,
        ST_DECOUPLED = 2'd2,
        ST_RECOUPLE  = 2'd3
    } dec_state_t;

    localparam int DRAIN_TIMEOUT_DEFAULT = 1024;
    localparam int RST_CYCLES_DEFAULT    = 16;
    localparam int OUTST_W_DEFAULT       = 4;

    // One timer serves both the drain window and the recouple reset window,
    // so it is sized for whichever is longer.
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/vs0_decoupler_wb_outst_cnt.sv
// ----------------------------------------------------------------------------
// wb_outst_cnt
// Saturating count of Wishbone pipelined requests accepted but not yet
// answered on one port.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_cyc          : bus cycle active; dropping it abandons all outstanding
//   i_inc          : request accepted this cycle (stb & !stall)
//   i_dec          : response seen this cycle (ack | err)
//   o_count        : current outstanding count
//   o_count_next   : value the count takes at the next clock edge
//   o_full         : count at maximum; owner must stall further requests
// ----------------------------------------------------------------------------
module wb_outst_cnt #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_cyc,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_count,
    output logic [W-1:0] o_count_next,
    output logic         o_full
);

    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] r_count;
    logic [W-1:0] w_count_next;

    // Simultaneous accept and response cancel out; both ends saturate so a
    // misbehaving peer can never wrap the count.
    always_comb begin
        w_count_next = r_count;
        if (!i_cyc) begin
            w_count_next = '0;
        end else if (i_inc && !i_dec) begin
            if (r_count != CNT_MAX) begin
                w_count_next = r_count + 1'b1;
            end
        end else if (i_dec && !i_inc) begin
            if (r_count != '0) begin
                w_count_next = r_count - 1'b1;
            end
        end
    end

    // Count register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign o_count      = r_count;
    assign o_count_next = w_count_next;
    assign o_full       = (r_count == CNT_MAX);

endmodule

// File: rtl/vs0_decoupler.sv
// ----------------------------------------------------------------------------
// vs0_decoupler
// Isolation wrapper between the crossbar and Virtual Socket 0. Transparent
// while coupled; around a partial reconfiguration it drains in-flight
// traffic, fences both Wishbone ports and the IRQ, holds VS0 in reset and
// then recouples.
//   i_sys_clk, i_rst_n  : clock, asynchronous active-low reset
//   i_decouple_req      : level request to isolate VS0
//   o_decouple_ack      : high while fully decoupled
//   o_drain_timeout     : sticky flag, drain was forced by the timeout
//   o_vs_rst_n          : reset to VS0 (low while decoupled / recoupling)
//   i_vs_wbm_* / o_vs_wbm_* : VS0 master port (VS0 side)
//   o_xb_wbm_* / i_xb_wbm_* : VS0 master port (crossbar side)
//   i_xb_wbs_* / o_xb_wbs_* : VS0 slave port (crossbar side)
//   o_vs_wbs_* / i_vs_wbs_* : VS0 slave port (VS0 side)
//   i_vs_irq, o_irq_out : VS0 interrupt in, gated interrupt out
// ----------------------------------------------------------------------------
module vs0_decoupler
    import vs_decoupler_pkg::*;
#(
    parameter int OUTST_W       = OUTST_W_DEFAULT,
    parameter int DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEFAULT,
    parameter int RST_CYCLES    = RST_CYCLES_DEFAULT
) (
    input  logic        i_sys_clk,
    input  logic        i_rst_n,
    input  logic        i_decouple_req,
    output logic        o_decouple_ack,
    output logic        o_drain_timeout,
    output logic        o_vs_rst_n,
    // VS0 master request / response
    input  logic [27:0] i_vs_wbm_adr,
    input  logic [31:0] i_vs_wbm_dat_o,
    input  logic        i_vs_wbm_we,
    input  logic [3:0]  i_vs_wbm_sel,
    input  logic        i_vs_wbm_stb,
    input  logic        i_vs_wbm_cyc,
    output logic [31:0] o_vs_wbm_dat_i,
    output logic        o_vs_wbm_ack,
    output logic        o_vs_wbm_stall,
    output logic        o_vs_wbm_err,
    // Crossbar side of the master port
    output logic [27:0] o_xb_wbm_adr,
    output logic [31:0] o_xb_wbm_dat_o,
    output logic        o_xb_wbm_we,
    output logic [3:0]  o_xb_wbm_sel,
    output logic        o_xb_wbm_stb,
    output logic        o_xb_wbm_cyc,
    input  logic [31:0] i_xb_wbm_dat_i,
    input  logic        i_xb_wbm_ack,
    input  logic        i_xb_wbm_stall,
    input  logic        i_xb_wbm_err,
    // Crossbar side of the slave port
    input  logic [17:0] i_xb_wbs_adr,
    input  logic [31:0] i_xb_wbs_dat_w,
    input  logic [3:0]  i_xb_wbs_sel,
    input  logic        i_xb_wbs_we,
    input  logic        i_xb_wbs_stb,
    input  logic        i_xb_wbs_cyc,
    output logic [31:0] o_xb_wbs_dat_r,
    output logic        o_xb_wbs_ack,
    output logic        o_xb_wbs_stall,
    output logic        o_xb_wbs_err,
    // VS0 side of the slave port
    output logic [17:0] o_vs_wbs_adr,
    output logic [31:0] o_vs_wbs_dat_w,
    output logic [3:0]  o_vs_wbs_sel,
    output logic        o_vs_wbs_we,
    output logic        o_vs_wbs_stb,
    output logic        o_vs_wbs_cyc,
    input  logic [31:0] i_vs_wbs_dat_r,
    input  logic        i_vs_wbs_ack,
    input  logic        i_vs_wbs_stall,
    input  logic        i_vs_wbs_err,
    // Interrupt
    input  logic        i_vs_irq,
    output logic        o_irq_out
);

    localparam int TMR_W = timer_width(DRAIN_TIMEOUT, RST_CYCLES);
    localparam logic [TMR_W-1:0] DRAIN_LAST = TMR_W'(DRAIN_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] RST_LAST   = TMR_W'(RST_CYCLES - 1);

    dec_state_t         r_state;
    dec_state_t         w_state_next;
    logic [TMR_W-1:0]   r_timer;
    logic [TMR_W-1:0]   w_timer_next;
    logic               r_drain_timeout;
    logic               w_to_set;
    logic               w_to_clr;

    logic [OUTST_W-1:0] w_mst_count;
    logic [OUTST_W-1:0] w_mst_count_next;
    logic               w_mst_full;
    logic [OUTST_W-1:0] w_slv_count;
    logic [OUTST_W-1:0] w_slv_count_next;
    logic               w_slv_full;

    logic               w_slv_busy;
    logic               w_drained;

    // Counters watch the crossbar-facing handshakes, i.e. what actually
    // went out of (or came into) the socket boundary after fencing.
    wb_outst_cnt #(.W(OUTST_W)) u_mst_cnt (
        .i_clk        (i_sys_clk),
        .i_rst_n      (i_rst_n),
        .i_cyc        (o_xb_wbm_cyc),
        .i_inc        (o_xb_wbm_stb & ~i_xb_wbm_stall),
        .i_dec        (i_xb_wbm_ack | i_xb_wbm_err),
        .o_count      (w_mst_count),
        .o_count_next (w_mst_count_next),
        .o_full       (w_mst_full)
    );

    wb_outst_cnt #(.W(OUTST_W)) u_slv_cnt (
        .i_clk        (i_sys_clk),
        .i_rst_n      (i_rst_n),
        .i_cyc        (i_xb_wbs_cyc),
        .i_inc        (i_xb_wbs_stb & ~o_xb_wbs_stall),
        .i_dec        (o_xb_wbs_ack | o_xb_wbs_err),
        .o_count      (w_slv_count),
        .o_count_next (w_slv_count_next),
        .o_full       (w_slv_full)
    );

    assign w_slv_busy = (w_slv_count != '0);
    // Looking at the next counts lets DRAIN leave on the edge that retires
    // the last response instead of one cycle later.
    assign w_drained  = (w_mst_count_next == '0) && (w_slv_count_next == '0);

    // Sequencer next-state and timer. The same timer measures the drain
    // window and the recouple reset window; it is cleared on every entry.
    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_to_set     = 1'b0;
        w_to_clr     = 1'b0;
        case (r_state)
            ST_COUPLED: begin
                if (i_decouple_req) begin
                    w_state_next = ST_DRAIN;
                    w_timer_next = '0;
                    w_to_clr     = 1'b1;
                end
            end
            ST_DRAIN: begin
                // The request level is deliberately not looked at here.
                if (w_drained) begin
                    w_state_next = ST_DECOUPLED;
                    w_timer_next = '0;
                end else if (r_timer == DRAIN_LAST) begin
                    w_state_next = ST_DECOUPLED;
                    w_timer_next = '0;
                    w_to_set     = 1'b1;
                end else begin
                    w_timer_next = r_timer + 1'b1;
                end
            end
            ST_DECOUPLED: begin
                if (!i_decouple_req && !w_slv_busy) begin
                    w_state_next = ST_RECOUPLE;
                    w_timer_next = '0;
                end
            end
            ST_RECOUPLE: begin
                if (i_decouple_req) begin
                    w_state_next = ST_DECOUPLED;
                    w_timer_next = '0;
                end else if (r_timer == RST_LAST) begin
                    // Errors owed for requests taken while recoupling must
                    // be paid before the port goes transparent again.
                    if (!w_slv_busy) begin
                        w_state_next = ST_COUPLED;
                        w_timer_next = '0;
                    end
                end else begin
                    w_timer_next = r_timer + 1'b1;
                end
            end
            default: begin
                w_state_next = ST_COUPLED;
                w_timer_next = '0;
            end
        endcase
    end

    // Sequencer state, timer and sticky timeout flag.
    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= ST_COUPLED;
            r_timer         <= '0;
            r_drain_timeout <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_timer <= w_timer_next;
            if (w_to_clr) begin
                r_drain_timeout <= 1'b0;
            end else if (w_to_set) begin
                r_drain_timeout <= 1'b1;
            end
        end
    end

    // Fencing muxes. Defaults are the fully fenced values (all data zero);
    // each state then opens up only what it needs.
    always_comb begin
        o_xb_wbm_adr   = '0;
        o_xb_wbm_dat_o = '0;
        o_xb_wbm_we    = 1'b0;
        o_xb_wbm_sel   = '0;
        o_xb_wbm_stb   = 1'b0;
        o_xb_wbm_cyc   = 1'b0;
        o_vs_wbm_dat_i = '0;
        o_vs_wbm_ack   = 1'b0;
        o_vs_wbm_err   = 1'b0;
        o_vs_wbm_stall = 1'b1;
        o_vs_wbs_adr   = '0;
        o_vs_wbs_dat_w = '0;
        o_vs_wbs_sel   = '0;
        o_vs_wbs_we    = 1'b0;
        o_vs_wbs_stb   = 1'b0;
        o_vs_wbs_cyc   = 1'b0;
        o_xb_wbs_dat_r = '0;
        o_xb_wbs_ack   = 1'b0;
        o_xb_wbs_err   = 1'b0;
        o_xb_wbs_stall = 1'b1;
        case (r_state)
            ST_COUPLED: begin
                // A full counter stalls its port and withholds stb on the
                // far side so the request is not taken twice.
                o_xb_wbm_adr   = i_vs_wbm_adr;
                o_xb_wbm_dat_o = i_vs_wbm_dat_o;
                o_xb_wbm_we    = i_vs_wbm_we;
                o_xb_wbm_sel   = i_vs_wbm_sel;
                o_xb_wbm_stb   = i_vs_wbm_stb & ~w_mst_full;
                o_xb_wbm_cyc   = i_vs_wbm_cyc;
                o_vs_wbm_dat_i = i_xb_wbm_dat_i;
                o_vs_wbm_ack   = i_xb_wbm_ack;
                o_vs_wbm_err   = i_xb_wbm_err;
                o_vs_wbm_stall = i_xb_wbm_stall | w_mst_full;
                o_vs_wbs_adr   = i_xb_wbs_adr;
                o_vs_wbs_dat_w = i_xb_wbs_dat_w;
                o_vs_wbs_sel   = i_xb_wbs_sel;
                o_vs_wbs_we    = i_xb_wbs_we;
                o_vs_wbs_stb   = i_xb_wbs_stb & ~w_slv_full;
                o_vs_wbs_cyc   = i_xb_wbs_cyc;
                o_xb_wbs_dat_r = i_vs_wbs_dat_r;
                o_xb_wbs_ack   = i_vs_wbs_ack;
                o_xb_wbs_err   = i_vs_wbs_err;
                o_xb_wbs_stall = i_vs_wbs_stall | w_slv_full;
            end
            ST_DRAIN: begin
                // No new requests in either direction; cyc is kept only
                // while responses are still owed, responses pass through.
                o_xb_wbm_adr   = i_vs_wbm_adr;
                o_xb_wbm_dat_o = i_vs_wbm_dat_o;
                o_xb_wbm_we    = i_vs_wbm_we;
                o_xb_wbm_sel   = i_vs_wbm_sel;
                o_xb_wbm_cyc   = (w_mst_count != '0);
                o_vs_wbm_dat_i = i_xb_wbm_dat_i;
                o_vs_wbm_ack   = i_xb_wbm_ack;
                o_vs_wbm_err   = i_xb_wbm_err;
                o_vs_wbs_adr   = i_xb_wbs_adr;
                o_vs_wbs_dat_w = i_xb_wbs_dat_w;
                o_vs_wbs_sel   = i_xb_wbs_sel;
                o_vs_wbs_we    = i_xb_wbs_we;
                o_vs_wbs_cyc   = i_xb_wbs_cyc & w_slv_busy;
                o_xb_wbs_dat_r = i_vs_wbs_dat_r;
                o_xb_wbs_ack   = i_vs_wbs_ack;
                o_xb_wbs_err   = i_vs_wbs_err;
            end
            default: begin
                // DECOUPLED / RECOUPLE: the slave port answers on VS0's
                // behalf. Every outstanding request (abandoned by a timeout
                // or newly accepted) earns one err per cycle until none are
                // owed, which gives a fresh request its err one cycle later.
                o_xb_wbs_stall = w_slv_full;
                o_xb_wbs_err   = w_slv_busy;
            end
        endcase
    end

    assign o_decouple_ack  = (r_state == ST_DECOUPLED);
    assign o_vs_rst_n      = ~((r_state == ST_DECOUPLED) || (r_state == ST_RECOUPLE));
    assign o_drain_timeout = r_drain_timeout;
    assign o_irq_out       = (r_state == ST_COUPLED) & i_vs_irq;

endmodule

// File: tb/tb_vs0_decoupler.sv
// ----------------------------------------------------------------------------
// tb_vs0_decoupler
// Directed bench for vs0_decoupler: passthrough, clean drain, drain timeout,
// fenced slave access, recouple and asynchronous reset. Expected responses
// are queued when a request is issued and compared when the response shows.
// ----------------------------------------------------------------------------
module tb_vs0_decoupler;

    logic        clk;
    logic        rstN;
    logic        decoupleReq;
    logic        decoupleAck;
    logic        drainTimeout;
    logic        vsRstN;
    logic [27:0] vsWbmAdr;
    logic [31:0] vsWbmDatO;
    logic        vsWbmWe;
    logic [3:0]  vsWbmSel;
    logic        vsWbmStb;
    logic        vsWbmCyc;
    logic [31:0] vsWbmDatI;
    logic        vsWbmAck;
    logic        vsWbmStall;
    logic        vsWbmErr;
    logic [27:0] xbWbmAdr;
    logic [31:0] xbWbmDatO;
    logic        xbWbmWe;
    logic [3:0]  xbWbmSel;
    logic        xbWbmStb;
    logic        xbWbmCyc;
    logic [31:0] xbWbmDatI;
    logic        xbWbmAck;
    logic        xbWbmStall;
    logic        xbWbmErr;
    logic [17:0] xbWbsAdr;
    logic [31:0] xbWbsDatW;
    logic [3:0]  xbWbsSel;
    logic        xbWbsWe;
    logic        xbWbsStb;
    logic        xbWbsCyc;
    logic [31:0] xbWbsDatR;
    logic        xbWbsAck;
    logic        xbWbsStall;
    logic        xbWbsErr;
    logic [17:0] vsWbsAdr;
    logic [31:0] vsWbsDatW;
    logic [3:0]  vsWbsSel;
    logic        vsWbsWe;
    logic        vsWbsStb;
    logic        vsWbsCyc;
    logic [31:0] vsWbsDatR;
    logic        vsWbsAck;
    logic        vsWbsStall;
    logic        vsWbsErr;
    logic        vsIrq;
    logic        irqOut;

    int total = 0;
    int bad   = 0;

    logic [31:0] mstQ[$];
    logic [32:0] slvQ[$];

    vs0_decoupler dut (
        .i_sys_clk      (clk),
        .i_rst_n        (rstN),
        .i_decouple_req (decoupleReq),
        .o_decouple_ack (decoupleAck),
        .o_drain_timeout(drainTimeout),
        .o_vs_rst_n     (vsRstN),
        .i_vs_wbm_adr   (vsWbmAdr),
        .i_vs_wbm_dat_o (vsWbmDatO),
        .i_vs_wbm_we    (vsWbmWe),
        .i_vs_wbm_sel   (vsWbmSel),
        .i_vs_wbm_stb   (vsWbmStb),
        .i_vs_wbm_cyc   (vsWbmCyc),
        .o_vs_wbm_dat_i (vsWbmDatI),
        .o_vs_wbm_ack   (vsWbmAck),
        .o_vs_wbm_stall (vsWbmStall),
        .o_vs_wbm_err   (vsWbmErr),
        .o_xb_wbm_adr   (xbWbmAdr),
        .o_xb_wbm_dat_o (xbWbmDatO),
        .o_xb_wbm_we    (xbWbmWe),
        .o_xb_wbm_sel   (xbWbmSel),
        .o_xb_wbm_stb   (xbWbmStb),
        .o_xb_wbm_cyc   (xbWbmCyc),
        .i_xb_wbm_dat_i (xbWbmDatI),
        .i_xb_wbm_ack   (xbWbmAck),
        .i_xb_wbm_stall (xbWbmStall),
        .i_xb_wbm_err   (xbWbmErr),
        .i_xb_wbs_adr   (xbWbsAdr),
        .i_xb_wbs_dat_w (xbWbsDatW),
        .i_xb_wbs_sel   (xbWbsSel),
        .i_xb_wbs_we    (xbWbsWe),
        .i_xb_wbs_stb   (xbWbsStb),
        .i_xb_wbs_cyc   (xbWbsCyc),
        .o_xb_wbs_dat_r (xbWbsDatR),
        .o_xb_wbs_ack   (xbWbsAck),
        .o_xb_wbs_stall (xbWbsStall),
        .o_xb_wbs_err   (xbWbsErr),
        .o_vs_wbs_adr   (vsWbsAdr),
        .o_vs_wbs_dat_w (vsWbsDatW),
        .o_vs_wbs_sel   (vsWbsSel),
        .o_vs_wbs_we    (vsWbsWe),
        .o_vs_wbs_stb   (vsWbsStb),
        .o_vs_wbs_cyc   (vsWbsCyc),
        .i_vs_wbs_dat_r (vsWbsDatR),
        .i_vs_wbs_ack   (vsWbsAck),
        .i_vs_wbs_stall (vsWbsStall),
        .i_vs_wbs_err   (vsWbsErr),
        .i_vs_irq       (vsIrq),
        .o_irq_out      (irqOut)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it and reports a failure with both values.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance n clock edges; inputs driven afterwards land 1 ns past the edge.
    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Master response seen by VS0 against the oldest queued read data.
    task automatic checkMstResp(input string tag);
        logic [31:0] e;
        checkOutput({tag, "_ack"}, {31'd0, vsWbmAck}, 32'd1);
        if (mstQ.size() == 0) begin
            checkOutput({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            e = mstQ.pop_front();
            checkOutput({tag, "_data"}, vsWbmDatI, e);
        end
    endtask

    // Slave response seen by the crossbar against the oldest queued {err,data}.
    task automatic checkSlvResp(input string tag);
        logic [32:0] e;
        if (slvQ.size() == 0) begin
            checkOutput({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            e = slvQ.pop_front();
            checkOutput({tag, "_ack"}, {31'd0, xbWbsAck}, {31'd0, ~e[32]});
            checkOutput({tag, "_err"}, {31'd0, xbWbsErr}, {31'd0, e[32]});
            checkOutput({tag, "_data"}, xbWbsDatR, e[31:0]);
        end
    endtask

    initial begin
        rstN = 1'b0; decoupleReq = 1'b0;
        vsWbmAdr = '0; vsWbmDatO = '0; vsWbmWe = 1'b0; vsWbmSel = '0; vsWbmStb = 1'b0; vsWbmCyc = 1'b0;
        xbWbmDatI = '0; xbWbmAck = 1'b0; xbWbmStall = 1'b0; xbWbmErr = 1'b0;
        xbWbsAdr = '0; xbWbsDatW = '0; xbWbsSel = '0; xbWbsWe = 1'b0; xbWbsStb = 1'b0; xbWbsCyc = 1'b0;
        vsWbsDatR = '0; vsWbsAck = 1'b0; vsWbsStall = 1'b0; vsWbsErr = 1'b0; vsIrq = 1'b0;

        // ---- reset values
        applyStimulus(2);
        checkOutput("rst_ack", {31'd0, decoupleAck}, 32'd0);
        checkOutput("rst_vs_rst_n", {31'd0, vsRstN}, 32'd1);
        checkOutput("rst_timeout", {31'd0, drainTimeout}, 32'd0);
        checkOutput("rst_irq", {31'd0, irqOut}, 32'd0);
        rstN = 1'b1;
        applyStimulus(1);

        // ---- idle passthrough: crossbar write then read to VS0 slave
        xbWbsCyc = 1'b1; xbWbsStb = 1'b1; xbWbsWe = 1'b1; xbWbsAdr = 18'h10;
        xbWbsDatW = 32'hDEADBEEF; xbWbsSel = 4'hF;
        #1;
        checkOutput("pt_wbs_adr", {14'd0, vsWbsAdr}, 32'h10);
        checkOutput("pt_wbs_dat", vsWbsDatW, 32'hDEADBEEF);
        checkOutput("pt_wbs_stb", {31'd0, vsWbsStb}, 32'd1);
        checkOutput("pt_wbs_we", {31'd0, vsWbsWe}, 32'd1);
        slvQ.push_back({1'b0, 32'h0});
        applyStimulus(1);
        xbWbsStb = 1'b0; vsWbsAck = 1'b1; vsWbsDatR = 32'h0;
        #1;
        checkSlvResp("pt_wr_resp");
        applyStimulus(1);
        vsWbsAck = 1'b0; xbWbsStb = 1'b1; xbWbsWe = 1'b0; xbWbsAdr = 18'h14;
        slvQ.push_back({1'b0, 32'h12345678});
        applyStimulus(1);
        xbWbsStb = 1'b0; vsWbsAck = 1'b1; vsWbsDatR = 32'h12345678;
        #1;
        checkSlvResp("pt_rd_resp");
        applyStimulus(1);
        vsWbsAck = 1'b0; xbWbsCyc = 1'b0; vsIrq = 1'b1;
        #1;
        checkOutput("pt_irq", {31'd0, irqOut}, 32'd1);

        // ---- clean drain: two reads accepted, third stalled
        vsWbmCyc = 1'b1; vsWbmStb = 1'b1; vsWbmAdr = 28'h100;
        #1;
        checkOutput("pt_wbm_stb", {31'd0, xbWbmStb}, 32'd1);
        checkOutput("pt_wbm_adr", {4'd0, xbWbmAdr}, 32'h100);
        mstQ.push_back(32'hA1A1A1A1);
        applyStimulus(1);
        vsWbmAdr = 28'h104; decoupleReq = 1'b1;
        mstQ.push_back(32'hA2A2A2A2);
        applyStimulus(1);
        vsWbmAdr = 28'h108;
        xbWbmAck = 1'b1; xbWbmDatI = 32'hA1A1A1A1;
        #1;
        checkOutput("drain_stall", {31'd0, vsWbmStall}, 32'd1);
        checkOutput("drain_xb_stb", {31'd0, xbWbmStb}, 32'd0);
        checkOutput("drain_xb_cyc", {31'd0, xbWbmCyc}, 32'd1);
        checkOutput("drain_irq", {31'd0, irqOut}, 32'd0);
        checkMstResp("drain_r1");
        applyStimulus(1);
        xbWbmDatI = 32'hA2A2A2A2;
        #1;
        checkMstResp("drain_r2");
        checkOutput("drain_ack_early", {31'd0, decoupleAck}, 32'd0);
        applyStimulus(1);
        xbWbmAck = 1'b0; vsWbmStb = 1'b0; vsWbmCyc = 1'b0;
        #1;
        checkOutput("drain_ack", {31'd0, decoupleAck}, 32'd1);
        checkOutput("drain_no_timeout", {31'd0, drainTimeout}, 32'd0);
        checkOutput("dec_vs_rst_n", {31'd0, vsRstN}, 32'd0);
        checkOutput("dec_xb_cyc", {31'd0, xbWbmCyc}, 32'd0);

        // ---- recouple, re-request in the 5th RECOUPLE cycle
        decoupleReq = 1'b0;
        applyStimulus(1);
        checkOutput("rec_ack", {31'd0, decoupleAck}, 32'd0);
        applyStimulus(4);
        checkOutput("rec_c5_rst_n", {31'd0, vsRstN}, 32'd0);
        decoupleReq = 1'b1;
        #1;
        checkOutput("rec_c5_ack", {31'd0, decoupleAck}, 32'd0);
        applyStimulus(1);
        checkOutput("rereq_ack", {31'd0, decoupleAck}, 32'd1);
        decoupleReq = 1'b0;
        applyStimulus(1);
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("rec_rst_low_%0d", i), {31'd0, vsRstN}, 32'd0);
            applyStimulus(1);
        end
        checkOutput("rec_rst_high", {31'd0, vsRstN}, 32'd1);
        checkOutput("rec_irq", {31'd0, irqOut}, 32'd1);

        // ---- counter saturation at 15 outstanding
        vsWbmCyc = 1'b1; vsWbmStb = 1'b1; vsWbmAdr = 28'h200;
        for (int i = 0; i < 15; i++) begin
            #1;
            checkOutput($sformatf("sat_stb_%0d", i), {31'd0, xbWbmStb}, 32'd1);
            mstQ.push_back(32'hB0000000 + i);
            applyStimulus(1);
        end
        #1;
        checkOutput("sat_stall", {31'd0, vsWbmStall}, 32'd1);
        checkOutput("sat_xb_stb", {31'd0, xbWbmStb}, 32'd0);
        vsWbmStb = 1'b0; xbWbmAck = 1'b1;
        for (int i = 0; i < 15; i++) begin
            xbWbmDatI = 32'hB0000000 + i;
            #1;
            checkMstResp($sformatf("sat_r%0d", i));
            applyStimulus(1);
        end
        xbWbmAck = 1'b0; vsWbmStb = 1'b1;
        #1;
        checkOutput("sat_released", {31'd0, vsWbmStall}, 32'd0);
        vsWbmStb = 1'b0; vsWbmCyc = 1'b0;
        applyStimulus(1);

        // ---- drain timeout: slave read VS0 never answers
        xbWbsCyc = 1'b1; xbWbsStb = 1'b1; xbWbsWe = 1'b0; xbWbsAdr = 18'h20;
        applyStimulus(1);
        xbWbsStb = 1'b0; decoupleReq = 1'b1;
        slvQ.push_back({1'b1, 32'h0});
        applyStimulus(1);
        checkOutput("to_flag_clear", {31'd0, drainTimeout}, 32'd0);
        checkOutput("to_vs_cyc", {31'd0, vsWbsCyc}, 32'd1);
        checkOutput("to_vs_stb", {31'd0, vsWbsStb}, 32'd0);
        checkOutput("to_xb_stall", {31'd0, xbWbsStall}, 32'd1);
        applyStimulus(1023);
        checkOutput("to_ack_1023", {31'd0, decoupleAck}, 32'd0);
        applyStimulus(1);
        checkOutput("to_ack_1024", {31'd0, decoupleAck}, 32'd1);
        checkOutput("to_flag", {31'd0, drainTimeout}, 32'd1);
        checkSlvResp("to_err");
        applyStimulus(1);
        checkOutput("to_err_once", {31'd0, xbWbsErr}, 32'd0);

        // ---- fenced access in DECOUPLED
        xbWbsStb = 1'b1; xbWbsWe = 1'b1; xbWbsAdr = 18'h0; xbWbsDatW = 32'hCAFEF00D;
        vsWbsAck = 1'b1; vsWbsDatR = 32'h55555555;
        #1;
        checkOutput("fence_stall", {31'd0, xbWbsStall}, 32'd0);
        checkOutput("fence_vs_cyc", {31'd0, vsWbsCyc}, 32'd0);
        checkOutput("fence_vs_stb", {31'd0, vsWbsStb}, 32'd0);
        checkOutput("fence_vs_dat", vsWbsDatW, 32'd0);
        checkOutput("fence_no_ack", {31'd0, xbWbsAck}, 32'd0);
        checkOutput("fence_err_early", {31'd0, xbWbsErr}, 32'd0);
        checkOutput("fence_irq", {31'd0, irqOut}, 32'd0);
        slvQ.push_back({1'b1, 32'h0});
        applyStimulus(1);
        xbWbsStb = 1'b0;
        #1;
        checkSlvResp("fence_resp");
        applyStimulus(1);
        checkOutput("fence_err_once", {31'd0, xbWbsErr}, 32'd0);
        vsWbsAck = 1'b0; xbWbsCyc = 1'b0;

        // ---- async reset in the middle of DRAIN
        decoupleReq = 1'b0;
        applyStimulus(17);
        checkOutput("back_coupled", {31'd0, vsRstN}, 32'd1);
        vsWbmCyc = 1'b1; vsWbmStb = 1'b1;
        applyStimulus(1);
        vsWbmStb = 1'b0; decoupleReq = 1'b1;
        applyStimulus(1);
        checkOutput("ar_in_drain", {31'd0, vsWbmStall}, 32'd1);
        checkOutput("ar_drain_cyc", {31'd0, xbWbmCyc}, 32'd1);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("ar_ack", {31'd0, decoupleAck}, 32'd0);
        checkOutput("ar_rst_n", {31'd0, vsRstN}, 32'd1);
        checkOutput("ar_timeout", {31'd0, drainTimeout}, 32'd0);
        checkOutput("ar_coupled_stall", {31'd0, vsWbmStall}, 32'd0);
        checkOutput("ar_coupled_irq", {31'd0, irqOut}, 32'd1);
        #1;
        rstN = 1'b1;
        applyStimulus(1);
        checkOutput("ar_cnt_zero", {31'd0, xbWbmCyc}, 32'd0);
        applyStimulus(1);
        checkOutput("ar_quick_decouple", {31'd0, decoupleAck}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
